// File: rtl/aes_pkg.sv
// Shared AES constants and types for the round-key store and its neighbours.
package aes_pkg;

  localparam int NUM_RK = 15;
  localparam int RK_W   = 128;
  localparam int IDX_W  = 4;

  typedef logic [RK_W-1:0]  rk_t;
  typedef logic [IDX_W-1:0] rk_idx_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } rks_state_t;

endpackage

// File: rtl/rk_regfile.sv
// NUM_RK x RK_W round-key storage: one synchronous write port, one registered read port.
module rk_regfile
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_en,
  input  rk_idx_t wr_addr,
  input  rk_t     wr_data,
  input  logic    rd_en,
  input  logic    rd_zero,
  input  rk_idx_t rd_addr,
  output rk_t     rd_data
);

  rk_t mem [NUM_RK];
  rk_t rd_q;

  // Storage is deliberately left unreset; contents only matter once rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rd_zero gates the array access so illegal indices never touch memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= rd_zero ? '0 : mem[rd_addr];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/round_key_store.sv
// Buffers the 15 AES-256 round keys from keyexpansion and serves them by round index.
//
// state   | meaning
// EMPTY   | no keys held since reset or clear
// FILLING | some keys written, schedule incomplete
// FULL    | all NUM_RK keys resident, writes blocked until clear
module round_key_store
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    rk_valid,
  input  rk_t     rk_data,
  output logic    rk_ready,
  input  logic    rd_en,
  input  rk_idx_t rd_idx,
  output rk_t     rd_data,
  output logic    rd_valid,
  output logic    rd_err,
  output logic    keys_ready,
  output rk_idx_t wr_count
);

  rks_state_t state_q, state_d;
  rk_idx_t    wr_count_q, wr_count_d;
  logic       alive_q;
  logic       rd_valid_q, rd_err_q;
  logic       wr_acc;
  logic       rd_illegal;

  // alive_q keeps rk_ready low until the first edge after reset release.
  assign rk_ready   = alive_q && (state_q != FULL) && !clear;
  assign wr_acc     = rk_valid && rk_ready;
  assign keys_ready = (state_q == FULL);
  assign rd_illegal = !keys_ready || (rd_idx >= rk_idx_t'(NUM_RK));

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    if (clear) begin
      state_d    = EMPTY;
      wr_count_d = '0;
    end else if (wr_acc) begin
      wr_count_d = wr_count_q + rk_idx_t'(1);
      if (wr_count_q == rk_idx_t'(NUM_RK - 1)) begin
        state_d = FULL;
      end else begin
        state_d = FILLING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      wr_count_q <= '0;
      alive_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      alive_q    <= 1'b1;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en && rd_illegal;
    end
  end

  // Reads see pre-clear keys_ready, so a read coincident with clear still succeeds.
  rk_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_count_q),
    .wr_data (rk_data),
    .rd_en   (rd_en),
    .rd_zero (rd_illegal),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store against an array/counter model of the key schedule.
module tb_round_key_store;
  import aes_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  logic    clear = 1'b0;
  logic    rk_valid = 1'b0;
  rk_t     rk_data = '0;
  logic    rk_ready;
  logic    rd_en = 1'b0;
  rk_idx_t rd_idx = '0;
  rk_t     rd_data;
  logic    rd_valid;
  logic    rd_err;
  logic    keys_ready;
  rk_idx_t wr_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: stored keys, how many, and whether the first post-reset edge has passed.
  rk_t m_mem [15];
  int  m_count = 0;
  bit  m_alive = 0;
  rk_t e_rd_data = '0;
  bit  e_rd_valid = 0;
  bit  e_rd_err = 0;

  round_key_store dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_ready   (rk_ready),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .keys_ready (keys_ready),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  function automatic rk_t rep(input int b);
    rk_t k;
    for (int i = 0; i < 16; i++) k[i*8 +: 8] = b[7:0];
    return k;
  endfunction

  function automatic rk_t rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit exp_rk_ready();
    return m_alive && (m_count < 15) && !clear;
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model, settle 1 time unit.
  task automatic cycle(input bit c, input bit v, input rk_t d, input bit re, input int idx);
    bit err;
    clear = c; rk_valid = v; rk_data = d; rd_en = re; rd_idx = idx[3:0];
    err = (m_count != 15) || (idx >= 15);
    @(posedge clk);
    e_rd_valid = re;
    e_rd_err   = re && err;
    if (re) e_rd_data = err ? '0 : m_mem[idx];
    if (c) m_count = 0;
    else if (v && m_alive && m_count < 15) begin
      m_mem[m_count] = d;
      m_count++;
    end
    m_alive = 1;
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0);
  endtask

  task automatic model_reset();
    m_count = 0; m_alive = 0;
    e_rd_data = '0; e_rd_valid = 0; e_rd_err = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if ({rk_ready, rd_valid, rd_err, keys_ready} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {rk_ready, rd_valid, rd_err, keys_ready}); else n_pass++;
    n_checks++; if (wr_count !== 4'd0) $display("FAIL reset_wr_count got %0d want 0", wr_count); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", rd_data); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (rk_ready !== 1'b0) $display("FAIL rk_ready_before_edge got %b want 0", rk_ready); else n_pass++;
    idle();
    n_checks++; if (rk_ready !== exp_rk_ready()) $display("FAIL rk_ready_after_edge got %b want %b", rk_ready, exp_rk_ready()); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, rep(i), 0, 0);
      n_checks++; if (wr_count !== rk_idx_t'(m_count)) $display("FAIL fill_wr_count got %0d want %0d", wr_count, m_count); else n_pass++;
      n_checks++; if (keys_ready !== (m_count == 15)) $display("FAIL fill_keys_ready got %b want %b at write %0d", keys_ready, m_count == 15, i); else n_pass++;
    end
    rk_valid = 0; #1;
    n_checks++; if (rk_ready !== 1'b0 || wr_count !== 4'd15) $display("FAIL fill_done got rdy=%b cnt=%0d want rdy=0 cnt=15", rk_ready, wr_count); else n_pass++;
  endtask

  task automatic test_reads();
    int idxs [3] = '{0, 7, 14};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, '0, 1, idxs[i]);
      n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) $display("FAIL read_flags idx %0d got v=%b e=%b want v=1 e=0", idxs[i], rd_valid, rd_err); else n_pass++;
      n_checks++; if (rd_data !== rep(idxs[i])) $display("FAIL read_data idx %0d got %h want %h", idxs[i], rd_data, rep(idxs[i])); else n_pass++;
    end
    idle();
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== rep(14)) $display("FAIL read_hold got v=%b d=%h want v=0 d=%h", rd_valid, rd_data, rep(14)); else n_pass++;
  endtask

  task automatic test_illegal_full();
    cycle(0, 0, '0, 1, 15);
    n_checks++; if (rd_err !== 1'b1 || rd_data !== '0 || rd_valid !== 1'b1) $display("FAIL idx15_read got v=%b e=%b d=%h want v=1 e=1 d=0", rd_valid, rd_err, rd_data); else n_pass++;
  endtask

  task automatic test_overflow();
    cycle(0, 1, rep(8'hFF), 0, 0);
    n_checks++; if (wr_count !== 4'd15 || keys_ready !== 1'b1) $display("FAIL overflow_state got cnt=%0d kr=%b want cnt=15 kr=1", wr_count, keys_ready); else n_pass++;
    cycle(0, 0, '0, 1, 0);
    n_checks++; if (rd_data !== rep(0) || rd_err !== 1'b0) $display("FAIL overflow_slot0 got %h e=%b want %h e=0", rd_data, rd_err, rep(0)); else n_pass++;
  endtask

  task automatic test_clear_collision();
    cycle(1, 1, rand_key(), 1, 2);
    n_checks++; if (rd_data !== rep(2) || rd_err !== 1'b0 || rd_valid !== 1'b1) $display("FAIL clear_read got v=%b e=%b d=%h want v=1 e=0 d=%h", rd_valid, rd_err, rd_data, rep(2)); else n_pass++;
    n_checks++; if (keys_ready !== 1'b0 || wr_count !== 4'd0) $display("FAIL clear_state got kr=%b cnt=%0d want kr=0 cnt=0", keys_ready, wr_count); else n_pass++;
    for (int i = 0; i < 5; i++) cycle(0, 1, rand_key(), 0, 0);
    n_checks++; if (wr_count !== 4'd5) $display("FAIL clear_dropped_write got cnt=%0d want 5", wr_count); else n_pass++;
    cycle(0, 1, rand_key(), 1, 3);
    n_checks++; if (rd_err !== 1'b1 || rd_data !== '0) $display("FAIL partial_read got e=%b d=%h want e=1 d=0", rd_err, rd_data); else n_pass++;
    while (m_count < 15) cycle(0, 1, rand_key(), 0, 0);
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, '0, 1, (i * 7) % 15);
      n_checks++; if (rd_data !== e_rd_data || rd_err !== 1'b0) $display("FAIL refill_read idx %0d got %h e=%b want %h e=0", (i * 7) % 15, rd_data, rd_err, e_rd_data); else n_pass++;
    end
  endtask

  task automatic test_reset_midfill();
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, rand_key(), 1, i);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++; if ({rk_ready, rd_valid, rd_err, keys_ready} !== 4'b0 || wr_count !== 4'd0 || rd_data !== '0) $display("FAIL async_reset got rdy=%b v=%b e=%b kr=%b cnt=%0d d=%h want all 0", rk_ready, rd_valid, rd_err, keys_ready, wr_count, rd_data); else n_pass++;
    clear = 0; rk_valid = 0; rd_en = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    idle();
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, rand_key(), 1, 0);
      n_checks++; if (rd_err !== 1'b1) $display("FAIL refill_early_read step %0d got e=%b want 1", i, rd_err); else n_pass++;
    end
    cycle(0, 0, '0, 1, 0);
    n_checks++; if (rd_err !== 1'b0 || rd_data !== e_rd_data) $display("FAIL refill_ok_read got e=%b d=%h want e=0 d=%h", rd_err, rd_data, e_rd_data); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, rand_key(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      n_checks++;
      if (rd_valid !== e_rd_valid || rd_err !== e_rd_err || rd_data !== e_rd_data)
        $display("FAIL rand_read cyc %0d got v=%b e=%b d=%h want v=%b e=%b d=%h", n, rd_valid, rd_err, rd_data, e_rd_valid, e_rd_err, e_rd_data);
      else n_pass++;
      n_checks++;
      if (wr_count !== rk_idx_t'(m_count) || keys_ready !== (m_count == 15) || rk_ready !== exp_rk_ready())
        $display("FAIL rand_state cyc %0d got cnt=%0d kr=%b rdy=%b want cnt=%0d kr=%b rdy=%b", n, wr_count, keys_ready, rk_ready, m_count, m_count == 15, exp_rk_ready());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reads();
    test_illegal_full();
    test_overflow();
    test_clear_collision();
    test_reset_midfill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
